// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - round-robin arbiter sharing a byte-wide memory between fetch and load/store ports
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_ack,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  busy,
    output logic                  grant_d
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [1:0]            beat;
    logic [ADDR_WIDTH-1:0] base;
    logic                  we_l;
    logic [31:0]           wdata_l;
    logic [31:0]           shift;
    logic                  err_l;
    logic                  last_d;
    logic                  pick_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           read_word;

    // On a tie the port that did not win last time is served; last_d=0 favours data first.
    assign pick_d    = d_req && (!i_req || !last_d);
    assign sel_addr  = pick_d ? d_addr : i_addr;
    assign read_word = {shift[23:0], mem_rdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            beat    <= 2'd0;
            base    <= '0;
            we_l    <= 1'b0;
            wdata_l <= 32'h0;
            shift   <= 32'h0;
            err_l   <= 1'b0;
            last_d  <= 1'b0;
            grant_d <= 1'b0;
            i_rdata <= 32'h0;
            d_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant_d <= pick_d;
                        last_d  <= pick_d;
                        base    <= sel_addr;
                        we_l    <= pick_d && d_we;
                        wdata_l <= pick_d ? d_wdata : 32'h0;
                        beat    <= 2'd0;
                        if (sel_addr[1:0] != 2'b00) begin
                            err_l <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_l <= 1'b0;
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (!we_l) begin
                        shift <= read_word;
                    end
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        state <= DONE;
                        // Load rdata on the last beat so it is valid alongside ack.
                        if (!we_l) begin
                            if (grant_d) begin
                                d_rdata <= read_word;
                            end else begin
                                i_rdata <= read_word;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign i_ack    = (state == DONE) && !grant_d;
    assign d_ack    = (state == DONE) && grant_d;
    assign i_err    = i_ack && err_l;
    assign d_err    = d_ack && err_l;
    assign mem_re   = (state == XFER) && !we_l;
    assign mem_we   = (state == XFER) && we_l;
    assign mem_addr = (state == XFER) ? (base + ADDR_WIDTH'(beat)) : '0;

    always_comb begin
        mem_wdata = 8'h00;
        if (state == XFER && we_l) begin
            case (beat)
                2'd0:    mem_wdata = wdata_l[31:24];
                2'd1:    mem_wdata = wdata_l[23:16];
                2'd2:    mem_wdata = wdata_l[15:8];
                default: mem_wdata = wdata_l[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic        mem_re;
    logic        busy;
    logic        grant_d;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .grant_d(grant_d)
    );

    // Byte memory: preloaded on the first edge, 0x10..0x13 = 12 34 56 78, rest zero.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
            mem[8'h10] <= 8'h12;
            mem[8'h11] <= 8'h34;
            mem[8'h12] <= 8'h56;
            mem[8'h13] <= 8'h78;
            mem_ready  <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic test_reset();
        rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0;
        #1;
        checks++;
        if ({i_rdata, d_rdata, mem_addr} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data i_rdata=%h d_rdata=%h mem_addr=%h expected all 0", i_rdata, d_rdata, mem_addr);
        end
        checks++;
        if ({i_ack, i_err, d_ack, d_err, mem_we, mem_re, busy, grant_d, mem_wdata} !== 16'h0) begin
            errors++;
            $display("FAIL reset_ctrl ack=%b%b err=%b%b we=%b re=%b busy=%b grant_d=%b wdata=%h expected 0",
                     i_ack, d_ack, i_err, d_err, mem_we, mem_re, busy, grant_d, mem_wdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b expected 0", busy); end
    endtask

    task automatic test_read();
        int re_cnt = 0;
        int ack_at = 0;
        logic [31:0] seen [4] = '{default: 32'hFFFF_FFFF};
        i_req = 1'b1; i_addr = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_re) begin
                if (re_cnt < 4) seen[re_cnt] = mem_addr;
                re_cnt++;
            end
            if (i_ack && ack_at == 0) begin
                ack_at = c;
                i_req = 1'b0;
                checks++;
                if (i_rdata !== 32'h12345678) begin errors++; $display("FAIL read_rdata got=%h expected=12345678", i_rdata); end
                checks++;
                if (i_err !== 1'b0 || grant_d !== 1'b0) begin errors++; $display("FAIL read_err_grant err=%b grant_d=%b expected 0 0", i_err, grant_d); end
            end
        end
        checks++;
        if (ack_at != 5) begin errors++; $display("FAIL read_latency ack_cycle=%0d expected=5", ack_at); end
        checks++;
        if (re_cnt != 4) begin errors++; $display("FAIL read_re_cycles got=%0d expected=4", re_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seen[k] !== 32'h10 + k) begin errors++; $display("FAIL read_beat_addr%0d got=%h expected=%h", k, seen[k], 32'h10 + k); end
        end
    endtask

    task automatic test_write();
        int we_cnt = 0;
        int ack_cnt = 0;
        int ack_at = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (d_ack) begin
                ack_cnt++;
                if (ack_at == 0) ack_at = c;
                d_req = 1'b0;
            end
        end
        d_we = 1'b0;
        checks++;
        if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_mem got=%h expected=deadbeef", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]});
        end
        checks++;
        if (we_cnt != 4) begin errors++; $display("FAIL write_we_cycles got=%0d expected=4", we_cnt); end
        checks++;
        if (ack_cnt != 1 || ack_at != 5) begin errors++; $display("FAIL write_ack count=%0d cycle=%0d expected 1 at 5", ack_cnt, ack_at); end
        checks++;
        if (d_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata_hold got=%h expected=0", d_rdata); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int dual = 0;
        int at [4] = '{default: 0};
        logic prt [4] = '{default: 1'bx};
        logic gd [4] = '{default: 1'bx};
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            @(negedge clk);
            if (i_ack && d_ack) dual++;
            if (i_ack || d_ack) begin
                at[n] = c; prt[n] = d_ack; gd[n] = grant_d; n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (n != 4 || dual != 0) begin errors++; $display("FAIL rr_ack_count got=%0d dual=%0d expected 4 0", n, dual); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (prt[k] !== ((k % 2) == 0) || gd[k] !== ((k % 2) == 0) || at[k] != 5 + 6 * k) begin
                errors++;
                $display("FAIL rr_grant%0d port_d=%b grant_d=%b cycle=%0d expected %b %b %0d",
                         k, prt[k], gd[k], at[k], (k % 2) == 0, (k % 2) == 0, 5 + 6 * k);
            end
        end
        checks++;
        if (d_rdata !== 32'hDEADBEEF || i_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL rr_rdata d=%h i=%h expected deadbeef 12345678", d_rdata, i_rdata);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle busy=%b expected 0", busy); end
    endtask

    task automatic test_misaligned();
        int bad = 0;
        int ack_at = 0;
        logic err_seen = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h22; d_wdata = 32'h11223344;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (mem_we || mem_re) bad++;
            if (d_ack && ack_at == 0) begin ack_at = c; err_seen = d_err; d_req = 1'b0; end
        end
        checks++;
        if (ack_at != 1 || err_seen !== 1'b1) begin errors++; $display("FAIL misaligned_ack cycle=%0d err=%b expected 1 1", ack_at, err_seen); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL misaligned_access strobes=%0d expected=0", bad); end
        checks++;
        if (d_rdata !== 32'hDEADBEEF || {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misaligned_side_effect rdata=%h mem=%h expected deadbeef deadbeef",
                     d_rdata, {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]});
        end
        ack_at = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (d_ack && ack_at == 0) begin
                ack_at = c; d_req = 1'b0;
                checks++;
                if (d_rdata !== 32'h12345678 || d_err !== 1'b0) begin
                    errors++;
                    $display("FAIL after_misaligned_read rdata=%h err=%b expected 12345678 0", d_rdata, d_err);
                end
            end
        end
        checks++;
        if (ack_at != 5) begin errors++; $display("FAIL after_misaligned_latency cycle=%0d expected=5", ack_at); end
    endtask

    task automatic test_reset_mid_xfer();
        int acks = 0;
        int ack_at = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h32) begin errors++; $display("FAIL midreset_beat2 we=%b addr=%h expected 1 00000032", mem_we, mem_addr); end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop we=%b re=%b busy=%b expected 0 0 0", mem_we, mem_re, busy);
        end
        d_req = 1'b0; d_we = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b1;
            if (d_ack || i_ack) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL midreset_no_ack acks=%0d expected=0", acks); end
        checks++;
        if ({mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]} !== 32'hCAFE0000 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_partial mem=%h d_rdata=%h expected cafe0000 0",
                     {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, d_rdata);
        end
        i_req = 1'b1; i_addr = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (i_ack && ack_at == 0) begin
                ack_at = c; i_req = 1'b0;
                checks++;
                if (i_rdata !== 32'h12345678) begin errors++; $display("FAIL midreset_readback got=%h expected=12345678", i_rdata); end
            end
        end
        checks++;
        if (ack_at != 5) begin errors++; $display("FAIL midreset_read_latency cycle=%0d expected=5", ack_at); end
    endtask

    task automatic test_drop_midway();
        int acks = 0;
        int ack_at = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) d_req = 1'b0;
            if (d_ack) begin
                acks++;
                if (ack_at == 0) begin
                    ack_at = c;
                    checks++;
                    if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL drop_rdata got=%h expected=deadbeef", d_rdata); end
                end
            end
        end
        checks++;
        if (acks != 1 || ack_at != 5) begin errors++; $display("FAIL drop_ack count=%0d cycle=%0d expected 1 at 5", acks, ack_at); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_misaligned();
        test_reset_mid_xfer();
        test_drop_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one byte-wide, combinational-read data memory between the instruction-fetch port (read-only) and the load/store port (read/write).
- Sequences each 32-bit access as four byte beats, big-endian: base+0 carries bits [31:24] and base+3 carries bits [7:0].
- Arbitrates round-robin and checks word alignment.
- Sits between the multicycle controller and the byte-array memory.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-port request (level).
- i_addr  in  ADDR_WIDTH  instruction word address.
- i_rdata  out  32  instruction read result.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  misalignment flag, valid with i_ack.
- d_req  in  1  data-port request (level).
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  32  write data.
- d_rdata  out  32  data read result.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  misalignment flag, valid with d_ack.
- mem_addr  out  ADDR_WIDTH  byte address to memory.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  byte read, combinational from mem_addr.
- mem_we  out  1  byte write strobe.
- mem_re  out  1  byte read strobe.
- busy  out  1  high whenever state is not IDLE.
- grant_d  out  1  1 = data port owns the current/last transfer.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat=0.
  - All outputs 0, including i_rdata, d_rdata and mem_addr.
  - Round-robin pointer last=instr, so the data port wins the first tie.
- States: IDLE, XFER, DONE.
- IDLE:
  - A port with req=1 is eligible.
  - If both ports are eligible, grant the port not granted last.
  - On grant: latch addr, we and wdata; set grant_d; update last.
  - If latched addr[1:0]!=0, go to DONE with err set and perform no memory access.
  - Otherwise go to XFER with beat=0.
  - If no port requests, stay in IDLE.
- XFER, one cycle per beat, 4 cycles total:
  - mem_addr = base + beat.
  - Reads: mem_re=1. On each edge, shift register = {shift[23:0], mem_rdata}.
  - Writes: mem_we=1. mem_wdata = wdata[31-8*beat -: 8].
  - At beat 3, go to DONE.
  - mem_we/mem_re are 0 in all other states.
- DONE, one cycle:
  - Assert ack and err on the granted port only.
  - On a successful read, that port's rdata is loaded from the shift register, timed so it is valid in the same cycle as ack.
  - Then go to IDLE.
- Latency: request sampled in IDLE at edge t → XFER cycles t+1..t+4 → ack in cycle t+5 → IDLE at t+6. A misaligned request acks in cycle t+1.
- Request protocol:
  - Requester holds req until it sees ack, then deasserts req at the following edge.
  - req=1 sampled in IDLE is always a new request.
  - Inputs are latched at grant; changes afterwards are ignored.
- Boundary conditions:
  - req dropped mid-transfer: the transfer completes and ack still pulses.
  - rdata of each port holds its value until the next successful read on that port. Writes and errors do not change rdata.
  - Address arithmetic is modulo 2^ADDR_WIDTH. An aligned base never crosses a word.
  - Reset mid-XFER: mem_we/mem_re drop immediately, no ack is issued, and the partial write is left in memory.
  - Continuous requests from both ports alternate grants d,i,d,i…; neither port can starve.

Test Plan:
- Memory bytes 0x10..0x13 = 12 34 56 78; i_req, i_addr=0x10 → mem_addr 0x10,0x11,0x12,0x13 over 4 cycles with mem_re=1; i_ack in 5th cycle after sampling; i_rdata=0x12345678; i_err=0.
- d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF → memory 0x20..0x23 = DE AD BE EF; mem_we high exactly 4 cycles; d_rdata unchanged; d_ack once.
- After reset, i_req and d_req raised the same cycle and both held continuously → grants data, instr, data, instr; grant_d sequence 1,0,1,0; each ack 6 cycles apart.
- d_req, d_we=1, d_addr=0x22 → d_ack and d_err in the next cycle; mem_we and mem_re never asserted; next aligned request served normally.
- Write in progress, rst asserted during beat 2 → mem_we low the same instant; busy=0; no d_ack; after release, a read of 0x10 returns 0x12345678.
- d_req read dropped after one XFER cycle → d_ack still pulses at cycle t+5 with valid d_rdata; arbiter returns to IDLE.
